// File: rtl/rs_latch_driver_if.sv
// rs_latch_driver_if: command/status handshake between controller and rs_latch_driver.
// Revision: 1.0
`default_nettype none

interface rs_latch_driver_if;
  logic cmd_set;
  logic cmd_reset;
  logic cmd_ready;
  logic done;
  logic err_conflict;
  logic err_timeout;
  logic err_clr;

  modport master (
    output cmd_set, cmd_reset, err_clr,
    input  cmd_ready, done, err_conflict, err_timeout
  );

  modport slave (
    input  cmd_set, cmd_reset, err_clr,
    output cmd_ready, done, err_conflict, err_timeout
  );
endinterface

`default_nettype wire

// File: rtl/rs_latch_driver.sv
// rs_latch_driver: turns set/reset commands into exclusive S/R pulses and confirms via Q/Q' feedback.
// Revision: 1.0
`default_nettype none

module rs_latch_driver #(
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_W          = 4
) (
  input  logic               clk,
  input  logic               rst,
  rs_latch_driver_if.slave   cmd,
  output logic               s_out,
  output logic               r_out,
  input  logic               q_fb,
  input  logic               qn_fb
);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CONFIRM = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             target, target_next;
  logic             q_meta, qn_meta, qs, qns;
  logic             done_next, conflict_next, timeout_evt;
  logic             match_set, match_rst, match_tgt;

  // Feedback comes straight from the latch, so it is resynchronised before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_meta  <= 1'b0;
      qn_meta <= 1'b0;
      qs      <= 1'b0;
      qns     <= 1'b0;
    end else begin
      q_meta  <= q_fb;
      qn_meta <= qn_fb;
      qs      <= q_meta;
      qns     <= qn_meta;
    end
  end

  assign match_set     = qs & ~qns;
  assign match_rst     = ~qs & qns;
  assign match_tgt     = target ? match_set : match_rst;
  assign cmd.cmd_ready = (state == IDLE);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    target_next   = target;
    done_next     = 1'b0;
    conflict_next = 1'b0;
    timeout_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd.cmd_set && cmd.cmd_reset) begin
          conflict_next = 1'b1;
        end else if (cmd.cmd_set) begin
          if (match_set) begin
            done_next = 1'b1;
          end else begin
            target_next = 1'b1;
            state_next  = DRIVE;
            cnt_next    = '0;
          end
        end else if (cmd.cmd_reset) begin
          if (match_rst) begin
            done_next = 1'b1;
          end else begin
            target_next = 1'b0;
            state_next  = DRIVE;
            cnt_next    = '0;
          end
        end
      end
      DRIVE: begin
        if (cnt == PULSE_LAST) begin
          state_next = CONFIRM;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      CONFIRM: begin
        // Match is tested first so it beats a coincident timeout.
        if (match_tgt) begin
          done_next  = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_evt = 1'b1;
          state_next  = IDLE;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      target           <= 1'b0;
      s_out            <= 1'b0;
      r_out            <= 1'b0;
      cmd.done         <= 1'b0;
      cmd.err_conflict <= 1'b0;
      cmd.err_timeout  <= 1'b0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      target           <= target_next;
      // Drives derive from a single target bit, so S and R can never overlap.
      s_out            <= (state_next == DRIVE) &  target_next;
      r_out            <= (state_next == DRIVE) & ~target_next;
      cmd.done         <= done_next;
      cmd.err_conflict <= conflict_next;
      if (timeout_evt)
        cmd.err_timeout <= 1'b1;
      else if (cmd.err_clr)
        cmd.err_timeout <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rs_latch_driver.sv
// tb_rs_latch_driver: directed stimulus with a queued scoreboard checked by an event monitor.
// Revision: 1.0
`default_nettype none

module tb_rs_latch_driver;

  localparam int EV_DONE     = 0;
  localparam int EV_CONFLICT = 1;
  localparam int EV_TIMEOUT  = 2;

  typedef struct {
    int   kind;
    logic q;
    int   s_cyc;
    int   r_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_out, r_out;
  logic q_fb = 1'b0;
  logic qn_fb = 1'b1;
  logic stuck = 1'b0;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  rs_latch_driver_if bus ();

  rs_latch_driver #(
    .PULSE_CYCLES   (2),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd   (bus.slave),
    .s_out (s_out),
    .r_out (r_out),
    .q_fb  (q_fb),
    .qn_fb (qn_fb)
  );

  always #5 clk = ~clk;

  // NOR latch model with one cycle of delay; 'stuck' forces both outputs low.
  always @(posedge clk) begin
    if (stuck) begin
      q_fb  <= 1'b0;
      qn_fb <= 1'b0;
    end else if (s_out) begin
      q_fb  <= 1'b1;
      qn_fb <= 1'b0;
    end else if (r_out) begin
      q_fb  <= 1'b0;
      qn_fb <= 1'b1;
    end
  end

  // Monitor: pops an expectation whenever the DUT reports an event.
  int   s_cnt = 0;
  int   r_cnt = 0;
  logic to_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      s_cnt   = 0;
      r_cnt   = 0;
      to_prev = 1'b0;
    end else begin
      if (s_out && r_out) begin
        miscompares++;
        $display("FAIL overlap: s_out=%b r_out=%b required not both 1", s_out, r_out);
      end
      if (s_out) s_cnt++;
      if (r_out) r_cnt++;
      if (bus.done || bus.err_conflict || (bus.err_timeout && !to_prev)) begin
        int   kind;
        exp_t e;
        kind = bus.done ? EV_DONE : (bus.err_conflict ? EV_CONFLICT : EV_TIMEOUT);
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: got kind=%0d, required none", kind);
        end else begin
          e = sb.pop_front();
          if (kind != e.kind || q_fb != e.q || s_cnt != e.s_cyc || r_cnt != e.r_cyc) begin
            miscompares++;
            $display("FAIL event: got kind=%0d q=%b s=%0d r=%0d, required kind=%0d q=%b s=%0d r=%0d",
                     kind, q_fb, s_cnt, r_cnt, e.kind, e.q, e.s_cyc, e.r_cyc);
          end
        end
        s_cnt = 0;
        r_cnt = 0;
      end
      to_prev = bus.err_timeout;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input logic q, input int s, input int r);
    exp_t e;
    e.kind  = kind;
    e.q     = q;
    e.s_cyc = s;
    e.r_cyc = r;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic set, input logic reset);
    bus.cmd_set   = set;
    bus.cmd_reset = reset;
    step(1);
    bus.cmd_set   = 1'b0;
    bus.cmd_reset = 1'b0;
  endtask

  // Waits for the scoreboard to drain, then idles to catch stray events.
  task automatic drain(input string name);
    int budget;
    budget = 60;
    while (sb.size() != 0 && budget > 0) begin
      step(1);
      budget--;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d events outstanding, required 0", name, sb.size());
      sb.delete();
    end
    step(4);
  endtask

  initial begin
    bus.cmd_set   = 1'b0;
    bus.cmd_reset = 1'b0;
    bus.err_clr   = 1'b0;
    #1;
    check("rst_ready", bus.cmd_ready, 1'b1);
    check("rst_s", s_out, 1'b0);
    check("rst_r", r_out, 1'b0);
    check("rst_timeout", bus.err_timeout, 1'b0);
    step(2);
    rst = 1'b0;
    step(3);

    // Reset asserted mid-pulse drops the drive immediately.
    pulse(1'b1, 1'b0);
    check("drive_s_high", s_out, 1'b1);
    check("drive_ready_low", bus.cmd_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("async_s_drop", s_out, 1'b0);
    check("async_r_drop", r_out, 1'b0);
    step(2);
    rst = 1'b0;
    step(1);
    check("post_rst_ready", bus.cmd_ready, 1'b1);
    check("post_rst_timeout", bus.err_timeout, 1'b0);
    step(3);

    // Set from Q=0.
    expect_ev(EV_DONE, 1'b1, 2, 0);
    pulse(1'b1, 1'b0);
    drain("set");

    // Conflicting command.
    expect_ev(EV_CONFLICT, 1'b1, 0, 0);
    pulse(1'b1, 1'b1);
    check("conflict_flag", bus.err_conflict, 1'b1);
    check("conflict_ready", bus.cmd_ready, 1'b1);
    drain("conflict");

    // Redundant set, then real reset, then redundant reset.
    expect_ev(EV_DONE, 1'b1, 0, 0);
    pulse(1'b1, 1'b0);
    check("redundant_set_done", bus.done, 1'b1);
    drain("redundant_set");
    expect_ev(EV_DONE, 1'b0, 0, 2);
    pulse(1'b0, 1'b1);
    drain("reset");
    expect_ev(EV_DONE, 1'b0, 0, 0);
    pulse(1'b0, 1'b1);
    check("redundant_reset_done", bus.done, 1'b1);
    drain("redundant_reset");

    // Reset command during DRIVE of a set is ignored.
    expect_ev(EV_DONE, 1'b1, 2, 0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    drain("busy");

    // Stuck feedback: timeout with no done, then clear.
    stuck = 1'b1;
    step(4);
    expect_ev(EV_TIMEOUT, 1'b0, 2, 0);
    pulse(1'b1, 1'b0);
    drain("timeout");
    check("timeout_sticky", bus.err_timeout, 1'b1);
    check("timeout_ready", bus.cmd_ready, 1'b1);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    check("timeout_cleared", bus.err_timeout, 1'b0);

    // Recovery after releasing the stuck latch.
    stuck = 1'b0;
    step(2);
    expect_ev(EV_DONE, 1'b0, 0, 2);
    pulse(1'b0, 1'b1);
    drain("recover");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
